// File: rtl/iob_reg_pipe_pkg.sv
// Shared constants and helpers for the elastic register pipeline.
package iob_reg_pipe_pkg;

    localparam int MIN_DEPTH = 1;

    // Width of the occupancy count; clamped so a bad DEPTH still elaborates far enough to report.
    function automatic int lvl_w(input int depth);
        return (depth < MIN_DEPTH) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/iob_reg_pipe_stage.sv
// One pipeline stage: valid bit plus payload register with load/drain/flush controls.
module iob_reg_pipe_stage
    import iob_reg_pipe_pkg::*;
#(
    parameter int                 DATA_W  = 32,
    parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              ld_i,
    input  logic              drain_i,
    input  logic [DATA_W-1:0] dat_i,
    output logic              vld_o,
    output logic [DATA_W-1:0] dat_o
);

    logic              vld_d, vld_q;
    logic [DATA_W-1:0] dat_d, dat_q;

    // Draining only drops the valid bit; the payload holds to avoid needless toggling.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (flush_i) begin
            vld_d = 1'b0;
            dat_d = RST_VAL;
        end else if (ld_i) begin
            vld_d = 1'b1;
            dat_d = dat_i;
        end else if (drain_i) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= 1'b0;
            dat_q <= RST_VAL;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign vld_o = vld_q;
    assign dat_o = dat_q;

endmodule

// File: rtl/iob_reg_pipe.sv
// Elastic DEPTH-stage register pipeline with bubble collapsing, global enable and flush.
module iob_reg_pipe
    import iob_reg_pipe_pkg::*;
#(
    parameter int                DATA_W  = 32,
    parameter int                DEPTH   = 2,
    parameter logic [DATA_W-1:0] RST_VAL = '0,
    localparam int               LEVEL_W = lvl_w(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    input  logic               out_ready,
    output logic [LEVEL_W-1:0] level
);

    if (DEPTH < MIN_DEPTH) begin : g_bad_depth
        $error("iob_reg_pipe: DEPTH must be >= 1");
    end

    logic                         go;
    logic [DEPTH:0]               vld;
    logic [DEPTH:0][DATA_W-1:0]   dat;
    logic [DEPTH+1:1]             rdy;
    logic [DEPTH:1]               ld, drain;

    assign go     = en & ~flush & ~rst;
    assign vld[0] = in_valid;
    assign dat[0] = in_data;

    // Ready ripples from the output back: any empty stage downstream lets everything behind it move.
    always_comb begin
        rdy          = '0;
        rdy[DEPTH+1] = out_ready;
        for (int i = DEPTH; i >= 1; i--) rdy[i] = ~vld[i] | rdy[i+1];
    end

    always_comb begin
        ld    = '0;
        drain = '0;
        level = '0;
        for (int i = 1; i <= DEPTH; i++) begin
            ld[i]    = go & vld[i-1] & rdy[i];
            drain[i] = go & vld[i] & rdy[i+1] & ~ld[i];
            level    = level + LEVEL_W'(vld[i]);
        end
    end

    for (genvar i = 1; i <= DEPTH; i++) begin : g_stage
        iob_reg_pipe_stage #(
            .DATA_W  (DATA_W),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk_i   (clk),
            .rst_i   (rst),
            .flush_i (flush),
            .ld_i    (ld[i]),
            .drain_i (drain[i]),
            .dat_i   (dat[i-1]),
            .vld_o   (vld[i]),
            .dat_o   (dat[i])
        );
    end

    assign in_ready  = go & rdy[1];
    assign out_valid = go & vld[DEPTH];
    assign out_data  = dat[DEPTH];

endmodule

// File: tb/tb_iob_reg_pipe.sv
// Bench for iob_reg_pipe: three depths driven in parallel, directed table, corner sequences, random scoreboard.
module tb_iob_reg_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1, en = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] in_data = '0;
    logic [2:0] irv, ovv;
    logic [7:0] od0, od1, od2;
    logic [1:0] lv0, lv1;
    logic [2:0] lv2;

    int n_chk = 0, n_fail = 0;
    int         DEP[3] = '{2, 3, 4};
    logic [7:0] RV[3]  = '{8'h00, 8'hFF, 8'h5A};

    always #5 clk = ~clk;

    iob_reg_pipe #(.DATA_W(8), .DEPTH(2), .RST_VAL(8'h00)) u_d2 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(irv[0]), .out_valid(ovv[0]), .out_data(od0), .out_ready(out_ready), .level(lv0));
    iob_reg_pipe #(.DATA_W(8), .DEPTH(3), .RST_VAL(8'hFF)) u_d3 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(irv[1]), .out_valid(ovv[1]), .out_data(od1), .out_ready(out_ready), .level(lv1));
    iob_reg_pipe #(.DATA_W(8), .DEPTH(4), .RST_VAL(8'h5A)) u_d4 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(irv[2]), .out_valid(ovv[2]), .out_data(od2), .out_ready(out_ready), .level(lv2));

    function automatic logic [7:0] odk(input int k);
        case (k) 0: return od0; 1: return od1; default: return od2; endcase
    endfunction

    function automatic int lvk(input int k);
        case (k) 0: return int'(lv0); 1: return int'(lv1); default: return int'(lv2); endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic e, input logic f, input logic v, input logic [7:0] d, input logic o);
        en = e; flush = f; in_valid = v; in_data = d; out_ready = o;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_rst();
        rst = 1'b1; in_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic e, f, v; logic [7:0] d; logic o;
        logic x_ir, x_ov; logic [7:0] x_od; int x_lv;
    } vec_t;
    vec_t tbl[14];

    logic [7:0] mq[3][$];
    logic       clean[3];
    int         npop[3];

    initial begin
        // en, flush, in_valid, in_data, out_ready | in_ready, out_valid, out_data, level  (DEPTH=3, RST_VAL=FF)
        tbl[0]  = '{1,0,1,8'h11,1, 1,0,8'hFF,0};
        tbl[1]  = '{1,0,1,8'h22,1, 1,0,8'hFF,1};
        tbl[2]  = '{1,0,1,8'h33,1, 1,0,8'hFF,2};
        tbl[3]  = '{1,0,0,8'h00,1, 1,1,8'h11,3};
        tbl[4]  = '{1,0,0,8'h00,1, 1,1,8'h22,2};
        tbl[5]  = '{1,0,0,8'h00,1, 1,1,8'h33,1};
        tbl[6]  = '{1,0,0,8'h00,1, 1,0,8'h33,0};
        tbl[7]  = '{1,0,1,8'h44,0, 1,0,8'h33,0};
        tbl[8]  = '{1,0,1,8'h55,0, 1,0,8'h33,1};
        tbl[9]  = '{1,0,1,8'h66,0, 1,0,8'h33,2};
        tbl[10] = '{1,0,1,8'h77,0, 0,1,8'h44,3};
        tbl[11] = '{1,1,1,8'h77,1, 0,0,8'h44,3};
        tbl[12] = '{1,0,0,8'h00,1, 1,0,8'hFF,0};
        tbl[13] = '{1,0,0,8'h00,1, 1,0,8'hFF,0};

        // reset state
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk("rst_in_ready", irv[k], 0);
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_level", lvk(k), 0);
            chk("rst_out_valid", ovv[k], 0);
            chk("rst_out_data", odk(k), RV[k]);
            chk("rst_in_ready", irv[k], 1);
        end
        tick();

        // streaming + flush table on DEPTH=3
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].e, tbl[i].f, tbl[i].v, tbl[i].d, tbl[i].o);
            chk($sformatf("tbl%0d_in_ready", i), irv[1], tbl[i].x_ir);
            chk($sformatf("tbl%0d_out_valid", i), ovv[1], tbl[i].x_ov);
            chk($sformatf("tbl%0d_out_data", i), od1, tbl[i].x_od);
            chk($sformatf("tbl%0d_level", i), lv1, tbl[i].x_lv);
            tick();
        end

        // DEPTH=3 full with back-pressure, then accept and emit in the same cycle
        do_rst();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 8'hA1 + 8'(i), 0);
            chk("bp_fill_ready", irv[1], 1);
            tick();
        end
        drive(1, 0, 1, 8'hA4, 0);
        chk("bp_full_ready", irv[1], 0);
        chk("bp_full_level", lv1, 3);
        tick();
        drive(1, 0, 1, 8'hA4, 1);
        chk("bp_swap_ready", irv[1], 1);
        chk("bp_swap_valid", ovv[1], 1);
        chk("bp_swap_data", od1, 8'hA1);
        tick();
        for (int j = 0; j < 3; j++) begin
            drive(1, 0, 0, 8'h00, 1);
            chk("bp_drain_valid", ovv[1], 1);
            chk("bp_drain_data", od1, 8'hA2 + 8'(j));
            tick();
        end

        // DEPTH=4 single word collapses to the last stage, then two more queue behind it
        do_rst();
        drive(1, 0, 1, 8'h0A, 0); tick();
        for (int i = 0; i < 3; i++) begin drive(1, 0, 0, 8'h00, 0); tick(); end
        drive(1, 0, 0, 8'h00, 0);
        chk("col_valid", ovv[2], 1);
        chk("col_data", od2, 8'h0A);
        chk("col_level", lv2, 1);
        tick();
        drive(1, 0, 1, 8'h0B, 0); chk("col_ready_b", irv[2], 1); tick();
        drive(1, 0, 1, 8'h0C, 0); chk("col_ready_c", irv[2], 1); tick();
        drive(1, 0, 0, 8'h00, 0); chk("col_level3", lv2, 3); tick();
        begin
            logic [7:0] exp_seq [3];
            int n;
            exp_seq = '{8'h0A, 8'h0B, 8'h0C};
            n = 0;
            for (int c = 0; c < 20 && n < 3; c++) begin
                drive(1, 0, 0, 8'h00, 1);
                if (ovv[2]) begin
                    chk("col_order", od2, exp_seq[n]);
                    n++;
                end
                tick();
            end
            chk("col_count", n, 3);
        end

        // DEPTH=2 frozen by en=0, then resumes
        do_rst();
        drive(1, 0, 1, 8'h05, 0); chk("en_fill5", irv[0], 1); tick();
        drive(1, 0, 1, 8'h06, 0); chk("en_fill6", irv[0], 1); tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 8'h07, 1);
            chk("en0_ready", irv[0], 0);
            chk("en0_valid", ovv[0], 0);
            chk("en0_level", lv0, 2);
            tick();
        end
        drive(1, 0, 0, 8'h00, 1); chk("en1_v5", ovv[0], 1); chk("en1_d5", od0, 8'h05); tick();
        drive(1, 0, 0, 8'h00, 1); chk("en1_v6", ovv[0], 1); chk("en1_d6", od0, 8'h06); tick();
        drive(1, 0, 0, 8'h00, 1); chk("en1_empty", ovv[0], 0); chk("en1_level", lv0, 0); tick();

        // random traffic against FIFO occupancy model, all depths at once
        do_rst();
        for (int k = 0; k < 3; k++) begin mq[k].delete(); clean[k] = 1'b1; npop[k] = 0; end
        for (int c = 0; c < 10000; c++) begin
            logic go;
            logic acc[3], pop[3];
            rst       = (c == 5000) || ($urandom_range(0, 999) == 0);
            flush     = ($urandom_range(0, 31) == 0);
            en        = ($urandom_range(0, 9) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            go = en & ~flush & ~rst;
            for (int k = 0; k < 3; k++) begin
                int sz;
                sz = mq[k].size();
                chk("rnd_in_ready", irv[k], go & ((sz < DEP[k]) | out_ready));
                chk("rnd_level", lvk(k), sz);
                if (ovv[k]) begin
                    chk("rnd_ghost", (sz > 0), 1);
                    if (sz > 0) chk("rnd_data", odk(k), mq[k][0]);
                end
                if (!go) chk("rnd_masked_valid", ovv[k], 0);
                if (clean[k] && sz == 0) chk("rnd_rst_data", odk(k), RV[k]);
                acc[k] = irv[k] & in_valid;
                pop[k] = ovv[k] & out_ready;
            end
            tick();
            for (int k = 0; k < 3; k++) begin
                if (rst || flush) begin
                    mq[k].delete();
                    clean[k] = 1'b1;
                end else begin
                    if (pop[k] && mq[k].size() > 0) begin
                        void'(mq[k].pop_front());
                        clean[k] = 1'b0;
                        npop[k]++;
                    end
                    if (acc[k]) mq[k].push_back(in_data);
                end
            end
        end
        rst = 1'b0; flush = 1'b0;
        for (int k = 0; k < 3; k++) chk("rnd_progress", (npop[k] > 100), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
